// File: rtl/sonar_pkg.sv
// Shared types and constants for the round-robin ultrasonic sonar scheduler.
package sonar_pkg;

  // Echo width / result field
  localparam int                 TIME_W   = 20;
  localparam logic [TIME_W-1:0]  TIME_MAX = 20'hFFFFF;

  // Default cycle constants (CLK cycles)
  localparam int DEF_N_SENS   = 4;
  localparam int DEF_TRIG_CYC = 500;
  localparam int DEF_TMO_CYC  = 1000000;
  localparam int DEF_HOLD_CYC = 200000;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // Largest of three cycle constants; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sonar_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no bus coherency is implied.
module sonar_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the raw pins; first stage may go metastable.
  // NOTE: every flop uses non-blocking (<=) so all stages update together at the edge.
  // NOTE: reset is synchronous and active-high, so it is tested inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for N_SENS single-pin ultrasonic sensors.
// Each measurement: trigger pulse, wait for echo rise, time echo width,
// report, then a quiet hold gap before moving to the next sensor.
// Optional feature: define SONAR_MASK_EN to add a MASK input that skips
// sensors whose mask bit is 1.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int N_SENS   = DEF_N_SENS,
  parameter int TRIG_CYC = DEF_TRIG_CYC,
  parameter int TMO_CYC  = DEF_TMO_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic [N_SENS-1:0]          SIG_IN,
  output logic [N_SENS-1:0]          SIG_OUT,
  output logic [N_SENS-1:0]          SIG_OE,
  output logic [19:0]                TIME,
  output logic [$clog2(N_SENS)-1:0]  TIME_ID,
  output logic                       TIME_VALID,
  output logic                       TIMEOUT,
  output logic                       BUSY
`ifdef SONAR_MASK_EN
  ,
  input  logic [N_SENS-1:0]          MASK
`endif
);

  localparam int ID_W    = $clog2(N_SENS);
  localparam int CNT_MAX = max3(TRIG_CYC, TMO_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts of the shared phase counter (counter starts at 0).
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  state_e              state_q,   state_d;
  logic [ID_W-1:0]     idx_q,     idx_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [TIME_W-1:0]   width_q,   width_d;
  logic [TIME_W-1:0]   time_q,    time_d;
  logic [ID_W-1:0]     time_id_q, time_id_d;
  logic                timeout_q, timeout_d;
  logic                valid_q,   valid_d;

  logic [N_SENS-1:0]   sig_sync;
  logic                echo;
  logic                tmo_hit;

  // Index candidates: "now" is used when leaving IDLE, "next" at end of HOLD.
  logic                sel_now_ok,  sel_next_ok;
  logic [ID_W-1:0]     sel_now_idx, sel_next_idx;

  sonar_sync #(
    .WIDTH (N_SENS)
  ) u_sig_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (SIG_IN),
    .q   (sig_sync)
  );

  // Round-robin successor, wrapping N_SENS-1 back to 0.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
    if (int'(i) == N_SENS - 1) return '0;
    else                       return i + 1'b1;
  endfunction

`ifdef SONAR_MASK_EN
  // First unmasked index at or after start (cyclic); MSB flags that one exists.
  function automatic logic [ID_W:0] pick_unmasked(input logic [ID_W-1:0]   start,
                                                  input logic [N_SENS-1:0] mask);
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] sel;
    logic            found;
    cand  = start;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < N_SENS; k++) begin
      if (!found && !mask[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = wrap_inc(cand);
    end
    return {found, sel};
  endfunction

  assign {sel_now_ok,  sel_now_idx}  = pick_unmasked(idx_q, MASK);
  assign {sel_next_ok, sel_next_idx} = pick_unmasked(wrap_inc(idx_q), MASK);
`else
  assign sel_now_ok   = 1'b1;
  assign sel_now_idx  = idx_q;
  assign sel_next_ok  = 1'b1;
  assign sel_next_idx = wrap_inc(idx_q);
`endif

  assign echo    = sig_sync[idx_q];
  assign tmo_hit = (cnt_q == TMO_LAST);

  // Next-state, counter and result computation for the measurement sequence.
  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    time_d    = time_q;
    time_id_d = time_id_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && sel_now_ok) begin
          state_d = ST_TRIG;
          idx_d   = sel_now_idx;
          cnt_d   = '0;
        end
      end

      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          cnt_d   = '0;            // timeout window starts at trigger release
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_RISE: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          time_d    = TIME_MAX;
          time_id_d = idx_q;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
        end else if (echo) begin
          state_d = ST_MEASURE;
          width_d = TIME_W'(1);    // the first high cycle already counts
        end
      end

      ST_MEASURE: begin
        cnt_d = cnt_q + 1'b1;
        // A falling edge wins over a simultaneous timeout.
        if (!echo) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          time_d    = width_q;
          time_id_d = idx_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
        end else if (tmo_hit) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          time_d    = TIME_MAX;
          time_id_d = idx_q;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
        end else if (width_q != TIME_MAX) begin
          width_d = width_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          idx_d   = sel_next_idx;
          cnt_d   = '0;
          state_d = (START && sel_next_ok) ? ST_TRIG : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Pin drive: only the selected sensor is driven, and only while triggering.
  always_comb begin
    SIG_OE  = '0;
    SIG_OUT = '0;
    if (state_q == ST_TRIG) begin
      SIG_OE[idx_q]  = 1'b1;
      SIG_OUT[idx_q] = 1'b1;
    end
  end

  // State and result registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      width_q   <= '0;
      time_q    <= '0;
      time_id_q <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      time_q    <= time_d;
      time_id_q <= time_id_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
    end
  end

  assign TIME       = time_q;
  assign TIME_ID    = time_id_q;
  assign TIMEOUT    = timeout_q;
  assign TIME_VALID = valid_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler with shortened cycle constants.
// A table of echo scenarios is run back-to-back with START held high,
// followed by hand-written reset, START-drop and (optionally) mask sequences.
module tb_sonar_scheduler;

  localparam int          N_SENS   = 4;
  localparam int          TRIG_CYC = 500;
  localparam int          TMO_CYC  = 1000;
  localparam int          HOLD_CYC = 50;
  localparam logic [19:0] TMAX     = 20'hFFFFF;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [3:0]  SIG_IN;
  logic [3:0]  SIG_OUT;
  logic [3:0]  SIG_OE;
  logic [19:0] TIME;
  logic [1:0]  TIME_ID;
  logic        TIME_VALID;
  logic        TIMEOUT;
  logic        BUSY;
`ifdef SONAR_MASK_EN
  logic [3:0]  MASK;
`endif

  int errors = 0;
  int checks = 0;

  logic [19:0] prev_time;
  logic [1:0]  prev_id;
  logic        prev_to;

  // One measurement: echo shape relative to trigger release, and expectations.
  typedef struct {
    int          delay;     // release-relative cycle where the echo goes high
    int          width;     // echo high cycles (0 = no echo)
    int          drop_at;   // release-relative cycle to drop START (-1 = never)
    bit          chk_gap;   // previous TIME_VALID is HOLD_CYC before this trigger
    logic [1:0]  exp_id;
    logic [19:0] exp_time;
    logic        exp_to;
    int          exp_lat;   // cycles from trigger release to TIME_VALID
  } meas_t;

  meas_t tbl [6];

  always #5 CLK = ~CLK;

  sonar_scheduler #(
    .N_SENS   (N_SENS),
    .TRIG_CYC (TRIG_CYC),
    .TMO_CYC  (TMO_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .SIG_IN     (SIG_IN),
    .SIG_OUT    (SIG_OUT),
    .SIG_OE     (SIG_OE),
    .TIME       (TIME),
    .TIME_ID    (TIME_ID),
    .TIME_VALID (TIME_VALID),
    .TIMEOUT    (TIMEOUT),
    .BUSY       (BUSY)
`ifdef SONAR_MASK_EN
    ,
    .MASK       (MASK)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge one cycle after the previous TIME_VALID (or from IDLE
  // just after raising START). Returns one negedge after this TIME_VALID.
  task automatic run_meas(input meas_t m);
    int n;
    int tl;
    int lat;
    bit got;

    n = 1;
    while (SIG_OE == '0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("trig_start_seen", SIG_OE != '0, 1'b1);
    if (SIG_OE == '0) return;

    if (m.chk_gap) begin
      check("hold_gap",  n, HOLD_CYC);
      check("time_held", TIME, prev_time);
      check("id_held",   TIME_ID, prev_id);
      check("to_held",   TIMEOUT, prev_to);
    end
    check("trig_oe",   SIG_OE,  4'b0001 << m.exp_id);
    check("trig_out",  SIG_OUT, 4'b0001 << m.exp_id);
    check("trig_busy", BUSY, 1'b1);

    tl = 0;
    while (SIG_OE != '0 && tl < TRIG_CYC + 10) begin
      @(negedge CLK);
      tl++;
    end
    check("trig_len", tl, TRIG_CYC);

    lat = 0;
    got = 1'b0;
    while (!got && lat < TMO_CYC + 50) begin
      if (TIME_VALID) begin
        got = 1'b1;
      end else begin
        if (lat == m.drop_at) START = 1'b0;
        SIG_IN[m.exp_id] = (m.width > 0) && (lat >= m.delay) && (lat < m.delay + m.width);
        @(negedge CLK);
        lat++;
      end
    end
    SIG_IN = '0;
    check("tv_seen", got, 1'b1);
    check("tv_lat",  lat, m.exp_lat);
    check("time",    TIME, m.exp_time);
    check("time_id", TIME_ID, m.exp_id);
    check("timeout", TIMEOUT, m.exp_to);
    prev_time = m.exp_time;
    prev_id   = m.exp_id;
    prev_to   = m.exp_to;

    @(negedge CLK);
    check("tv_pulse", TIME_VALID, 1'b0);
  endtask

  initial begin
    int n;
    int tv_cnt;

    //           delay width drop gap id     time        to    lat
    tbl[0] = '{10,   150,  -1, 1'b0, 2'd0, 20'd150, 1'b0, 163};   // plain echo
    tbl[1] = '{0,    0,    -1, 1'b1, 2'd1, TMAX,    1'b1, 1000};  // no echo
    tbl[2] = '{0,    1,    -1, 1'b1, 2'd2, 20'd1,   1'b0, 4};     // shortest echo
    tbl[3] = '{5,    992,  -1, 1'b1, 2'd3, 20'd992, 1'b0, 1000};  // fall on timeout cycle
    tbl[4] = '{5,    993,  -1, 1'b1, 2'd0, TMAX,    1'b1, 1000};  // one cycle too long
    tbl[5] = '{3,    300,  -1, 1'b1, 2'd1, 20'd300, 1'b0, 306};

    RESET  = 1'b1;
    START  = 1'b0;
    SIG_IN = '0;
`ifdef SONAR_MASK_EN
    MASK   = '0;
`endif
    prev_time = '0;
    prev_id   = '0;
    prev_to   = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_oe",      SIG_OE, 4'b0000);
    check("rst_out",     SIG_OUT, 4'b0000);
    check("rst_time",    TIME, 20'd0);
    check("rst_id",      TIME_ID, 2'd0);
    check("rst_valid",   TIME_VALID, 1'b0);
    check("rst_timeout", TIMEOUT, 1'b0);
    check("rst_busy",    BUSY, 1'b0);

    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    check("idle_busy", BUSY, 1'b0);
    check("idle_oe",   SIG_OE, 4'b0000);

    // Continuous polling through the scenario table.
    START = 1'b1;
    for (int i = 0; i < 6; i++) run_meas(tbl[i]);

    // Reset on the 200th cycle of the next trigger (sensor 2).
    n = 1;
    while (SIG_OE == '0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("rst_trig_pin", SIG_OE, 4'b0100);
    repeat (199) @(negedge CLK);
    check("rst_trig_200", SIG_OE, 4'b0100);
    RESET = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    check("midtrig_rst_oe",   SIG_OE, 4'b0000);
    check("midtrig_rst_out",  SIG_OUT, 4'b0000);
    check("midtrig_rst_busy", BUSY, 1'b0);
    RESET = 1'b0;
    tv_cnt = 0;
    repeat (1200) begin
      @(negedge CLK);
      if (TIME_VALID) tv_cnt++;
    end
    check("midtrig_no_tv", tv_cnt, 0);
    check("midtrig_time",  TIME, 20'd0);
    prev_time = '0;
    prev_id   = '0;
    prev_to   = 1'b0;

    // START dropped mid-MEASURE: result still reported, then HOLD, then IDLE.
    START = 1'b1;
    run_meas('{2, 100, 50, 1'b0, 2'd0, 20'd100, 1'b0, 105});
    repeat (HOLD_CYC - 2) @(negedge CLK);
    check("drop_hold_busy", BUSY, 1'b1);
    @(negedge CLK);
    check("drop_idle_busy", BUSY, 1'b0);
    repeat (20) @(negedge CLK);
    check("drop_stay_idle", BUSY, 1'b0);
    check("drop_idle_oe",   SIG_OE, 4'b0000);

    // Restart from IDLE continues with the next sensor.
    START = 1'b1;
    run_meas('{0, 20, -1, 1'b0, 2'd1, 20'd20, 1'b0, 23});

`ifdef SONAR_MASK_EN
    START = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    MASK  = 4'b0101;
    prev_time = '0;
    prev_id   = '0;
    prev_to   = 1'b0;
    START = 1'b1;
    run_meas('{1, 40, -1, 1'b0, 2'd1, 20'd40, 1'b0, 44});
    run_meas('{1, 60, -1, 1'b1, 2'd3, 20'd60, 1'b0, 64});
    run_meas('{1, 80, -1, 1'b1, 2'd1, 20'd80, 1'b0, 84});
    MASK = 4'b1111;
    repeat (HOLD_CYC) @(negedge CLK);
    check("mask_all_busy", BUSY, 1'b0);
    repeat (100) @(negedge CLK);
    check("mask_all_stay", BUSY, 1'b0);
    check("mask_all_oe",   SIG_OE, 4'b0000);
`endif

    START = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hang guard.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
